// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit.
//   OP_BRANCH / OP_JAL / OP_JALR : opcodes that the unit resolves
//   br_func3_e                   : conditional-branch condition encodings
//   br_stage_t                   : one pipeline entry, as captured at accept
// br_stage_t is sized for the widest supported datapath (BR_MAX_XLEN).
// Narrower units zero-extend into it and read back the low XLEN bits.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int BR_MAX_XLEN = 64;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_func3_e;

    typedef struct packed {
        logic                   valid;
        logic                   taken;
        logic [BR_MAX_XLEN-1:0] target;
        logic [BR_MAX_XLEN-1:0] link;
        logic                   pred_taken;
        logic [BR_MAX_XLEN-1:0] pred_target;
    } br_stage_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
//   opcode, func3 : instruction fields
//   rs1, rs2      : source operands
//   taken         : resolved direction (JAL/JALR always taken)
//   is_jalr       : target comes from rs1+imm rather than pc+imm
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            is_jalr
);

    logic            is_unsigned;
    logic [XLEN:0]   rs1_ext;
    logic [XLEN:0]   rs2_ext;
    logic            eq;
    logic            lt;

    // One XLEN+1 bit signed compare covers both signednesses: the operands
    // are sign-extended for BLT/BGE and zero-extended for BLTU/BGEU.
    always_comb begin
        is_unsigned = func3[1];
        rs1_ext     = {(rs1[XLEN-1] & ~is_unsigned), rs1};
        rs2_ext     = {(rs2[XLEN-1] & ~is_unsigned), rs2};
        eq          = (rs1 == rs2);
        lt          = ($signed(rs1_ext) < $signed(rs2_ext));

        taken   = 1'b0;
        is_jalr = 1'b0;
        case (opcode)
            OP_BRANCH: begin
                case (br_func3_e'(func3))
                    BEQ:     taken = eq;
                    BNE:     taken = ~eq;
                    BLT:     taken = lt;
                    BGE:     taken = ~lt;
                    BLTU:    taken = lt;
                    BGEU:    taken = ~lt;
                    default: taken = 1'b0;
                endcase
            end
            OP_JAL:  taken = 1'b1;
            OP_JALR: begin
                taken   = 1'b1;
                is_jalr = 1'b1;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolution unit for the execute stage.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop every in-flight entry at the next edge
//   in_valid/in_ready   : input handshake; opcode, func3, operands, pc, imm
//   pred_taken/target   : front-end prediction to check against
//   out_valid/out_ready : output handshake
//   out_taken/target    : resolved direction and next PC
//   out_link            : pc+4
//   out_mispredict      : prediction was wrong
//   mispredict_count    : saturating count of committed mispredicts
// PIPE_STAGES (1 or 2) sets both the register depth and the latency.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic [CNT_W-1:0] mispredict_count
);

    logic            taken_c;
    logic            is_jalr_c;
    logic [XLEN-1:0] br_sum;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link_sum;
    logic [XLEN-1:0] target_c;
    br_stage_t       entry_c;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .opcode  (opcode),
        .func3   (func3),
        .rs1     (rs1_val),
        .rs2     (rs2_val),
        .taken   (taken_c),
        .is_jalr (is_jalr_c)
    );

    // Target/link adders; sums wrap modulo 2^XLEN. JALR clears bit 0.
    always_comb begin
        br_sum   = pc + imm;
        jalr_sum = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
        link_sum = pc + XLEN'(4);
        target_c = taken_c ? (is_jalr_c ? jalr_sum : br_sum) : link_sum;

        entry_c             = '0;
        entry_c.valid       = in_valid;
        entry_c.taken       = taken_c;
        entry_c.target      = BR_MAX_XLEN'(target_c);
        entry_c.link        = BR_MAX_XLEN'(link_sum);
        entry_c.pred_taken  = pred_taken;
        entry_c.pred_target = BR_MAX_XLEN'(pred_target);
    end

    if (PIPE_STAGES == 1) begin : g_one_stage
        br_stage_t s0_q, s0_d;
        logic      s0_ready;
        logic      unused_s0;

        // Single stage: loads when empty or when its entry leaves this cycle.
        // The mispredict compare sits after the register.
        always_comb begin
            s0_ready = !s0_q.valid || out_ready;
            s0_d     = s0_q;
            if (s0_ready) begin
                s0_d.valid = in_valid;
                if (in_valid) begin
                    s0_d = entry_c;
                end
            end
            if (flush) begin
                s0_d.valid = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s0_q <= '0;
            end else begin
                s0_q <= s0_d;
            end
        end

        assign in_ready       = s0_ready;
        assign out_valid      = s0_q.valid;
        assign out_taken      = s0_q.taken;
        assign out_target     = s0_q.target[XLEN-1:0];
        assign out_link       = s0_q.link[XLEN-1:0];
        assign out_mispredict = (s0_q.taken != s0_q.pred_taken) ||
                                (s0_q.taken && (s0_q.target != s0_q.pred_target));
        assign unused_s0      = ^{s0_q.target, s0_q.link};
    end else begin : g_two_stage
        br_stage_t       s1_q, s1_d;
        logic            s2_valid_q, s2_valid_d;
        logic            s2_taken_q, s2_taken_d;
        logic            s2_mis_q, s2_mis_d;
        logic [XLEN-1:0] s2_target_q, s2_target_d;
        logic [XLEN-1:0] s2_link_q, s2_link_d;
        logic            s1_ready;
        logic            s2_ready;
        logic            s1_mis_c;
        logic            unused_s1;

        // Stage 1 holds the resolved direction and sums; stage 2 holds the
        // mispredict result. Each stage loads when empty or draining.
        always_comb begin
            s2_ready = !s2_valid_q || out_ready;
            s1_ready = !s1_q.valid || s2_ready;
            s1_mis_c = (s1_q.taken != s1_q.pred_taken) ||
                       (s1_q.taken && (s1_q.target != s1_q.pred_target));

            s1_d = s1_q;
            if (s1_ready) begin
                s1_d.valid = in_valid;
                if (in_valid) begin
                    s1_d = entry_c;
                end
            end

            s2_valid_d  = s2_valid_q;
            s2_taken_d  = s2_taken_q;
            s2_mis_d    = s2_mis_q;
            s2_target_d = s2_target_q;
            s2_link_d   = s2_link_q;
            if (s2_ready) begin
                s2_valid_d = s1_q.valid;
                if (s1_q.valid) begin
                    s2_taken_d  = s1_q.taken;
                    s2_mis_d    = s1_mis_c;
                    s2_target_d = s1_q.target[XLEN-1:0];
                    s2_link_d   = s1_q.link[XLEN-1:0];
                end
            end

            if (flush) begin
                s1_d.valid = 1'b0;
                s2_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q        <= '0;
                s2_valid_q  <= 1'b0;
                s2_taken_q  <= 1'b0;
                s2_mis_q    <= 1'b0;
                s2_target_q <= '0;
                s2_link_q   <= '0;
            end else begin
                s1_q        <= s1_d;
                s2_valid_q  <= s2_valid_d;
                s2_taken_q  <= s2_taken_d;
                s2_mis_q    <= s2_mis_d;
                s2_target_q <= s2_target_d;
                s2_link_q   <= s2_link_d;
            end
        end

        assign in_ready       = s1_ready;
        assign out_valid      = s2_valid_q;
        assign out_taken      = s2_taken_q;
        assign out_target     = s2_target_q;
        assign out_link       = s2_link_q;
        assign out_mispredict = s2_mis_q;
        assign unused_s1      = ^{s1_q.target, s1_q.link};
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts mispredicts as they are handed to the consumer, sticking at
    // all-ones. Flush does not touch it.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && out_mispredict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_count = cnt_q;

endmodule
